data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_bram.sv | 22 ++
 rtl/data_mem_ctrl.sv | 69 ++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-type encodings, FSM states, ROM defaults and load formatting.
package dmem_pkg;
  typedef enum logic [2:0] {ACC_B = 3'd0, ACC_H = 3'd1, ACC_W = 3'd2, ACC_BU = 3'd3, ACC_HU = 3'd4} acc_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  localparam logic [31:0] ROM_WORD0_DEF = 32'h1719_2051;
  localparam logic [31:0] ROM_WORD1_DEF = 32'h1672_6992;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  typ;
  } req_t;
  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    return t == ACC_B  ? {{24{b[7]}}, b} :
           t == ACC_BU ? {24'b0, b} :
           t == ACC_H  ? {{16{h[15]}}, h} :
           t == ACC_HU ? {16'b0, h} : w;
  endfunction
endpackage

// File: rtl/dmem_bram.sv
// dmem_bram: single-port word RAM with byte-enable write and registered read.
module dmem_bram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en_i,
  input  logic [3:0]                     we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++)
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      rdata_q <= mem_q[addr_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: one-request-at-a-time load/store controller over a RAM window and a 2-word ROM.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] RAM_BASE    = 32'h8000_0000,
  parameter logic [31:0] ROM_BASE    = 32'h0010_0000,
  parameter logic [31:0] ROM_WORD0   = ROM_WORD0_DEF,
  parameter logic [31:0] ROM_WORD1   = ROM_WORD1_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_type,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t      state_q, state_d;
  req_t        req_q;
  logic [31:0] off_ram, off_rom, ram_rdata, word, wlane;
  logic [3:0]  be;
  logic        in_ram, in_rom, mis, err;
  always_ff @(posedge clk) begin
    state_q <= rst ? ST_IDLE : state_d;
    if (req_valid && req_ready) req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, typ: req_type};
  end
  always_comb begin
    state_d = state_q == ST_IDLE   ? (req_valid ? ST_ACCESS : ST_IDLE) :
              state_q == ST_ACCESS ? ST_RESP :
              (rsp_ready ? ST_IDLE : ST_RESP);
  end
  // Decode is driven purely by the captured request, so it stays stable through RESP.
  always_comb begin
    off_ram = req_q.addr - RAM_BASE;
    off_rom = req_q.addr - ROM_BASE;
    in_ram  = off_ram < 32'(DEPTH_WORDS * 4);
    in_rom  = off_rom < 32'd8;
    mis     = ((req_q.typ == ACC_H || req_q.typ == ACC_HU) && req_q.addr[0]) ||
              (req_q.typ == ACC_W && req_q.addr[1:0] != 2'b00);
    err     = req_q.typ > 3'd4 || (req_q.we && (req_q.typ == ACC_BU || req_q.typ == ACC_HU)) ||
              mis || !(in_ram || in_rom) || (req_q.we && in_rom);
    be      = req_q.typ == ACC_B ? 4'(4'b0001 << req_q.addr[1:0]) :
              req_q.typ == ACC_H ? (req_q.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wlane   = req_q.typ == ACC_B ? {4{req_q.wdata[7:0]}} :
              req_q.typ == ACC_H ? {2{req_q.wdata[15:0]}} : req_q.wdata;
    word    = in_rom ? (off_rom[2] ? ROM_WORD1 : ROM_WORD0) : ram_rdata;
  end
  always_comb begin
    req_ready = state_q == ST_IDLE && !rst;
    rsp_valid = state_q == ST_RESP && !rst;
    rsp_err   = rsp_valid && err;
    rsp_rdata = (rsp_valid && !err && !req_q.we) ? load_fmt(word, req_q.addr[1:0], req_q.typ) : 32'h0;
  end
  dmem_bram #(.DEPTH_WORDS(DEPTH_WORDS)) u_bram (
    .clk     (clk),
    .en_i    (state_q == ST_ACCESS && in_ram && !err && !rst),
    .we_i    (req_q.we ? be : 4'b0000),
    .addr_i  (off_ram[AW+1:2]),
    .wdata_i (wlane),
    .rdata_o (ram_rdata)
  );
endmodule
